// File: rtl/instr_encode_loader.sv
// instr_encode_loader: packs decoded MIPS fields back into 32-bit words and
// streams them into instruction memory until a HALT word is written or the
// memory fills up. Fed by the debug unit over a valid/ready handshake.
module instr_encode_loader #(
    parameter int          ADDR_W      = 8,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       immediate,
    input  logic [25:0]       address,
    input  logic [31:0]       raw,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              overflow
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Count value reached when every memory slot holds a word.
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;

    logic                accept;
    logic [31:0]         enc_word;
    logic                is_halt;
    logic                is_full;

    function automatic logic [31:0] encode(
        input logic [1:0]  f,
        input logic [5:0]  op,
        input logic [4:0]  r_s,
        input logic [4:0]  r_t,
        input logic [4:0]  r_d,
        input logic [4:0]  sh,
        input logic [5:0]  fn,
        input logic [15:0] imm,
        input logic [25:0] adr,
        input logic [31:0] rw
    );
        logic [31:0] w;
        case (f)
            2'b00:   w = {op, r_s, r_t, r_d, sh, fn};
            2'b01:   w = {op, r_s, r_t, imm};
            2'b10:   w = {op, adr};
            default: w = rw;
        endcase
        return w;
    endfunction

    // Handshake and word encoding; HALT is judged on the final encoded word.
    always_comb begin
        in_ready = (state_q == ST_LOAD) && !clear;
        accept   = in_valid && in_ready;
        enc_word = encode(fmt, opcode, rs, rt, rd, shamt, funct,
                          immediate, address, raw);
        is_halt  = (enc_word[31:26] == HALT_OPCODE);
        is_full  = ((word_count_q + 1'b1) == FULL_CNT);
    end

    // Next-state: clear restarts the session, otherwise an accept writes a word.
    always_comb begin
        state_d      = state_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        if (clear) begin
            state_d      = ST_LOAD;
            word_count_d = '0;
            done_d       = 1'b0;
            overflow_d   = 1'b0;
        end else if (accept) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = word_count_q[ADDR_W-1:0];
            mem_wdata_d  = enc_word;
            word_count_d = word_count_q + 1'b1;
            if (is_halt || is_full) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            if (is_full && !is_halt) begin
                overflow_d = 1'b1;
            end
        end
    end

    // State and registered outputs; reset aborts any pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign word_count = word_count_q;
    assign done       = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Testbench for instr_encode_loader: a default-size instance (ADDR_W=8) and a
// small instance (ADDR_W=2) share one stimulus stream.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic [1:0]  fmt;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [31:0] raw;

    logic        a_ready, a_we, a_done, a_ovf;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata;
    logic [8:0]  a_cnt;

    logic        b_ready, b_we, b_done, b_ovf;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(a_ready), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .immediate(immediate),
        .address(address), .raw(raw), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .word_count(a_cnt), .done(a_done),
        .overflow(a_ovf)
    );

    instr_encode_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(b_ready), .fmt(fmt), .opcode(opcode), .rs(rs), .rt(rt),
        .rd(rd), .shamt(shamt), .funct(funct), .immediate(immediate),
        .address(address), .raw(raw), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .word_count(b_cnt), .done(b_done),
        .overflow(b_ovf)
    );

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] adr;
        logic [31:0] raw;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fmt       = v.fmt;
        opcode    = v.op;
        rs        = v.rs;
        rt        = v.rt;
        rd        = v.rd;
        shamt     = v.sh;
        funct     = v.fn;
        immediate = v.imm;
        address   = v.adr;
        raw       = v.raw;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unused fields carry junk to show they are ignored.
        vecs[0] = '{2'b00, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0, 6'h21, 16'hBEEF, 26'h3FFFFFF, 32'hDEADBEEF, 32'h00221821};
        vecs[1] = '{2'b01, 6'h08, 5'd1,  5'd2,  5'd31, 5'd7, 6'h3F, 16'h0005, 26'h1234567, 32'hFFFFFFFF, 32'h20220005};
        vecs[2] = '{2'b10, 6'h02, 5'd9,  5'd9,  5'd9,  5'd9, 6'h09, 16'hAAAA, 26'h0000010, 32'h0,        32'h08000010};
        vecs[3] = '{2'b11, 6'h00, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h0,       32'hFC000000, 32'hFC000000};
        vecs[4] = '{2'b01, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0, 6'h00, 16'hFFFC, 26'h0,       32'h0,        32'h8FA8FFFC};
        vecs[5] = '{2'b00, 6'h00, 5'd0,  5'd10, 5'd9,  5'd4, 6'h00, 16'h0000, 26'h0,       32'h0,        32'h000A4900};
        vecs[6] = '{2'b11, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0, 6'h00, 16'h0000, 26'h0,       32'h12345678, 32'h12345678};

        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        drive(vecs[0]);
        step();
        step();

        // Reset state
        chk("rst_we",    a_we,    0);
        chk("rst_addr",  a_addr,  0);
        chk("rst_wdata", a_wdata, 0);
        chk("rst_cnt",   a_cnt,   0);
        chk("rst_done",  a_done,  0);
        chk("rst_ovf",   a_ovf,   0);
        chk("rst_ready", a_ready, 1);
        rst_n = 1'b1;
        step();

        // Table: R, I, J back-to-back then raw HALT at addr 3
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            step();
            chk($sformatf("tbl%0d_we", i),    a_we,    1);
            chk($sformatf("tbl%0d_addr", i),  a_addr,  i);
            chk($sformatf("tbl%0d_wdata", i), a_wdata, vecs[i].exp);
            chk($sformatf("tbl%0d_cnt", i),   a_cnt,   i + 1);
        end
        chk("halt_done",  a_done,  1);
        chk("halt_ovf",   a_ovf,   0);
        chk("halt_ready", a_ready, 0);
        // Small instance: HALT landed in its last slot
        chk("b_lastslot_cnt",  b_cnt,  4);
        chk("b_lastslot_done", b_done, 1);
        chk("b_lastslot_ovf",  b_ovf,  0);

        // DONE ignores in_valid; outputs hold
        drive(vecs[4]);
        step();
        chk("done_we",    a_we,    0);
        chk("done_cnt",   a_cnt,   4);
        chk("done_wdata", a_wdata, 32'hFC000000);
        chk("done_addr",  a_addr,  3);
        step();
        chk("done_we2",   a_we,    0);

        // clear from DONE with a bundle presented in the clear cycle
        clear = 1'b1;
        #1;
        chk("clear_ready", a_ready, 0);
        step();
        chk("clear_we",   a_we,   0);
        chk("clear_cnt",  a_cnt,  0);
        chk("clear_done", a_done, 0);
        chk("clear_ovf",  a_ovf,  0);
        chk("b_clear_done", b_done, 0);
        clear = 1'b0;
        step();
        chk("post_clear_we",    a_we,    1);
        chk("post_clear_addr",  a_addr,  0);
        chk("post_clear_wdata", a_wdata, 32'h8FA8FFFC);
        chk("post_clear_cnt",   a_cnt,   1);
        in_valid = 1'b0;
        step();
        chk("idle_we",  a_we,  0);
        chk("idle_cnt", a_cnt, 1);

        // Overflow on the small instance: four non-HALT words
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[(i + 4) % 7]);
            in_valid = 1'b1;
            step();
            chk($sformatf("ovf%0d_we", i),    b_we,    1);
            chk($sformatf("ovf%0d_addr", i),  b_addr,  i);
            chk($sformatf("ovf%0d_wdata", i), b_wdata, vecs[(i + 4) % 7].exp);
        end
        chk("ovf_cnt",   b_cnt,   4);
        chk("ovf_done",  b_done,  1);
        chk("ovf_flag",  b_ovf,   1);
        chk("ovf_ready", b_ready, 0);
        chk("a_nohalt_done", a_done, 0);
        chk("a_nohalt_cnt",  a_cnt,  4);
        step();
        chk("ovf_after_we", b_we, 0);
        in_valid = 1'b0;

        // Async reset right after an accept edge drops the pending write
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(vecs[0]);
        in_valid = 1'b1;
        step();
        chk("pre_rst_we", a_we, 1);
        rst_n = 1'b0;
        #1;
        chk("async_we",    a_we,    0);
        chk("async_addr",  a_addr,  0);
        chk("async_wdata", a_wdata, 0);
        chk("async_cnt",   a_cnt,   0);
        // Reset held across an edge with a bundle presented: nothing written
        step();
        chk("held_rst_we",  a_we,  0);
        chk("held_rst_cnt", a_cnt, 0);
        #2;
        rst_n = 1'b1;
        drive(vecs[2]);
        step();
        chk("after_rst_we",    a_we,    1);
        chk("after_rst_addr",  a_addr,  0);
        chk("after_rst_wdata", a_wdata, 32'h08000010);
        chk("after_rst_cnt",   a_cnt,   1);
        in_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
